instr_fetch: RTL
================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 The block SHALL have port clk, input, 1 bit: rising-edge clock.
REQ-002 The block SHALL have port Resetn, input, 1 bit: reset, synchronous, active-low.
REQ-003 The block SHALL have port start, input, 1 bit: level enable; fetching proceeds while high.
REQ-004 The block SHALL have port mem_addr, output, 8 bits: instruction memory word address.
REQ-005 The block SHALL have port mem_rd, output, 1 bit: memory read strobe; mem_data is valid the cycle after.
REQ-006 The block SHALL have port mem_data, input, 9 bits: memory read data.
REQ-007 The block SHALL have port ir, output, 9 bits: instruction to control unit, {cmd[8:6], adr1[5:3], adr2[2:0]}.
REQ-008 The block SHALL have port din, output, 9 bits: immediate/operand word for MVI and JMP.
REQ-009 The block SHALL have port Run, output, 1 bit: one-cycle issue pulse to control unit.
REQ-010 The block SHALL have port done, input, 1 bit: control unit completion.
REQ-011 The block SHALL have port jmp, input, 1 bit: control unit jump-taken indication, sampled with done.
REQ-012 The block SHALL have port pc, output, 8 bits: current program counter.
REQ-013 The block SHALL have port busy, output, 1 bit: high in every state except IDLE.

Function
REQ-014 The FSM SHALL have states IDLE, FETCH, DECODE, OPFETCH, OPLOAD, ISSUE, EXEC.
REQ-015 IDLE SHALL go to FETCH when start=1, else stay in IDLE.
REQ-016 FETCH SHALL assert mem_rd=1 with mem_addr=pc for exactly one cycle, then go to DECODE.
REQ-017 DECODE SHALL load ir<=mem_data.
REQ-018 In DECODE, cmd 011 (MVI) or 100 (JMP) SHALL go to OPFETCH; cmd 000/001/010 SHALL go to ISSUE; cmd 101-111 SHALL set pc<=pc+1 with no Run pulse and go to FETCH (start=1) or IDLE (start=0).
REQ-019 OPFETCH SHALL assert mem_rd=1 with mem_addr=pc+1 (8-bit wrap), then go to OPLOAD.
REQ-020 OPLOAD SHALL load din<=mem_data, then go to ISSUE.
REQ-021 ISSUE SHALL assert Run=1 for exactly one cycle, then go to EXEC.
REQ-022 ir and din SHALL remain stable from DECODE/OPLOAD until EXEC is left.
REQ-023 EXEC SHALL hold Run=0 and wait for done=1.
REQ-024 On done=1 with jmp=1, the block SHALL set pc<=din[7:0].
REQ-025 On done=1 with jmp=0, the block SHALL set pc<=pc+2 for MVI and pc<=pc+1 otherwise.
REQ-026 After done=1 the FSM SHALL go to FETCH if start=1, else to IDLE.
REQ-027 All pc arithmetic SHALL be modulo 256 (255+1=0, 255+2=1).
REQ-028 start falling mid-instruction SHALL NOT abort the instruction; the block SHALL return to IDLE at the instruction boundary.
REQ-029 done=1 outside EXEC SHALL be ignored.
REQ-030 mem_rd SHALL be high only in FETCH and OPFETCH; mem_addr SHALL equal pc in all other states.
REQ-031 Instruction latency SHALL be: ALU/MV, Run 2 cycles after FETCH entry; MVI/JMP, Run 4 cycles after FETCH entry.

Reset
REQ-032 With Resetn=0 at a clk edge, the block SHALL set state=IDLE, pc=0, ir=0, din=0, Run=0, mem_rd=0, busy=0 (plus the REQ-036 outputs when compiled in).
REQ-033 Reset SHALL take priority over done, start and all state activity, including mid-EXEC; no pc update SHALL occur on the reset edge.

Configuration
REQ-034 Macro IFETCH_WDOG_EN SHALL compile in an EXEC watchdog.
REQ-035 With IFETCH_WDOG_EN defined, a 4-bit counter SHALL clear on EXEC entry and increment each EXEC cycle without done.
REQ-036 With IFETCH_WDOG_EN defined, when that count reaches 15 the block SHALL set sticky output wdog_err=1, set pc<=pc+1 and go to IDLE; wdog_err SHALL clear only on reset.
REQ-037 Without IFETCH_WDOG_EN, the wdog_err port and the counter SHALL be absent, and EXEC SHALL wait indefinitely.

Verification
REQ-038 The bench SHALL cover: reset, mem[0]=9'b000_001_010 (ADD), start=1, done 2 cycles after Run -> Run at cycle 2, ir=0x00A, pc 0->1.
REQ-039 The bench SHALL cover: mem[4]=9'b011_011_000 (MVI), mem[5]=0x1A5, pc=4 -> OPFETCH addr 5, din=0x1A5, Run once, pc->6 after done.
REQ-040 The bench SHALL cover: mem[7]=JMP (9'b100_000_000), mem[8]=0x030, done with jmp=1 -> pc=0x30, next FETCH addr 0x30.
REQ-041 The bench SHALL cover: pc=255 holding MV -> pc=0 after done; pc=255 holding MVI -> operand read at addr 0, pc=1.
REQ-042 The bench SHALL cover: opcode 101 at pc=3 -> no Run pulse, pc=4; start dropped during EXEC -> instruction completes, then IDLE with busy=0.
REQ-043 The bench SHALL cover: Resetn=0 during EXEC -> next cycle IDLE, pc=0, Run=0; with IFETCH_WDOG_EN, done withheld -> wdog_err=1 after 15 EXEC cycles.

Source files
------------

// File: rtl/instr_fetch.sv
// Instruction fetch/issue sequencer: reads opcode (and operand for MVI/JMP), issues Run,
// then waits for done to advance pc. Optional EXEC watchdog compiled in by IFETCH_WDOG_EN.
module instr_fetch (
  input  logic       clk,
  input  logic       Resetn,
  input  logic       start,
  output logic [7:0] mem_addr,
  output logic       mem_rd,
  input  logic [8:0] mem_data,
  output logic [8:0] ir,
  output logic [8:0] din,
  output logic       Run,
  input  logic       done,
  input  logic       jmp,
  output logic [7:0] pc,
  output logic       busy
`ifdef IFETCH_WDOG_EN
  ,
  output logic       wdog_err
`endif
);

  typedef enum logic [2:0] {
    StIdle, StFetch, StDecode, StOpfetch, StOpload, StIssue, StExec
  } state_e;

  localparam logic [2:0] CmdMvi = 3'b011;
  localparam logic [2:0] CmdJmp = 3'b100;

  state_e     state_q, state_d;
  logic [7:0] pc_q, pc_d;
  logic [8:0] ir_q, ir_d;
  logic [8:0] din_q, din_d;
  logic [2:0] cmd;
  logic       wdog_fire;

  // Opcode is decoded straight off the memory bus in DECODE, before ir is loaded.
  assign cmd = mem_data[8:6];

`ifdef IFETCH_WDOG_EN
  logic [3:0] wdog_cnt_q, wdog_cnt_d;
  logic       wdog_err_q, wdog_err_d;

  // Fires on the edge that would take the count to 15, i.e. after 15 EXEC cycles without done.
  assign wdog_fire = (state_q == StExec) && !done && (wdog_cnt_q == 4'd14);

  always_comb begin
    wdog_cnt_d = wdog_cnt_q;
    wdog_err_d = wdog_err_q | wdog_fire;
    if (state_q == StIssue) begin
      wdog_cnt_d = 4'd0;
    end else if ((state_q == StExec) && !done) begin
      wdog_cnt_d = wdog_cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!Resetn) begin
      wdog_cnt_q <= 4'd0;
      wdog_err_q <= 1'b0;
    end else begin
      wdog_cnt_q <= wdog_cnt_d;
      wdog_err_q <= wdog_err_d;
    end
  end

  assign wdog_err = wdog_err_q;
`else
  assign wdog_fire = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!Resetn) begin
      state_q <= StIdle;
      pc_q    <= 8'd0;
      ir_q    <= 9'd0;
      din_q   <= 9'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      din_q   <= din_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (start) state_d = StFetch;
      StFetch:   state_d = StDecode;
      StDecode: begin
        if ((cmd == CmdMvi) || (cmd == CmdJmp)) begin
          state_d = StOpfetch;
        end else if (cmd < CmdMvi) begin
          state_d = StIssue;
        end else begin
          state_d = start ? StFetch : StIdle;
        end
      end
      StOpfetch: state_d = StOpload;
      StOpload:  state_d = StIssue;
      StIssue:   state_d = StExec;
      StExec: begin
        if (done) begin
          state_d = start ? StFetch : StIdle;
        end else if (wdog_fire) begin
          state_d = StIdle;
        end
      end
      default:   state_d = StIdle;
    endcase
  end

  always_comb begin
    pc_d  = pc_q;
    ir_d  = ir_q;
    din_d = din_q;
    if (state_q == StDecode) begin
      ir_d = mem_data;
      if (cmd > CmdJmp) pc_d = pc_q + 8'd1;
    end
    if (state_q == StOpload) din_d = mem_data;
    if (state_q == StExec) begin
      if (done) begin
        if (jmp) begin
          pc_d = din_q[7:0];
        end else if (ir_q[8:6] == CmdMvi) begin
          pc_d = pc_q + 8'd2;
        end else begin
          pc_d = pc_q + 8'd1;
        end
      end else if (wdog_fire) begin
        pc_d = pc_q + 8'd1;
      end
    end
  end

  always_comb begin
    mem_rd   = (state_q == StFetch) || (state_q == StOpfetch);
    mem_addr = (state_q == StOpfetch) ? pc_q + 8'd1 : pc_q;
    Run      = (state_q == StIssue);
    busy     = (state_q != StIdle);
  end

  assign pc  = pc_q;
  assign ir  = ir_q;
  assign din = din_q;

endmodule
